accel_ip_axil_regs: RTL and testbench

ACCEL_IP_AXIL_REGS -- requirements
Module: accel_ip_axil_regs

---
 rtl/accel_ip_pkg.sv | 28 ++
 rtl/accel_ip_axil_regs.sv | 189 ++++++++++++++++++
 tb/tb_accel_ip_axil_regs.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/accel_ip_pkg.sv
// Shared constants and FSM state types for the accelerator AXI4-Lite register block.
package accel_ip_pkg;

    localparam int NUM_REGS = 4;

    localparam logic [1:0] REG0_IDX = 2'd0;
    localparam logic [1:0] REG1_IDX = 2'd1;
    localparam logic [1:0] REG2_IDX = 2'd2;
    localparam logic [1:0] REG3_IDX = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT_AW,
        W_WAIT_W,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

endpackage

// File: rtl/accel_ip_axil_regs.sv
// AXI4-Lite slave with four R/W control registers and a start pulse for the accelerator core.
// start_o is registered: it is high in the first cycle reg0_o shows the written value.
module accel_ip_axil_regs
    import accel_ip_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg0_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg1_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg2_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg3_o,
    output logic                              start_o
);

    localparam int DATA_W = C_S_AXI_DATA_WIDTH;
    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

    logic [DATA_W-1:0] regs [NUM_REGS];
    w_state_t          w_state, w_next;
    r_state_t          r_state, r_next;
    logic              ready_en;

    logic [1:0]        aw_idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;

    logic              aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic              wr_en;
    logic [1:0]        wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic [STRB_W-1:0] wr_strb;

    logic              unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_val,
                                                      input logic [DATA_W-1:0] new_val,
                                                      input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] res;
        res = old_val;
        for (int n = 0; n < STRB_W; n++) begin
            if (strb[n]) res[8*n +: 8] = new_val[8*n +: 8];
        end
        return res;
    endfunction

    // Holds every READY low until the first edge after reset release.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) ready_en <= 1'b0;
        else              ready_en <= 1'b1;
    end

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
    assign b_hs  = S_AXI_BVALID  && S_AXI_BREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
    assign r_hs  = S_AXI_RVALID  && S_AXI_RREADY;

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) w_state <= W_IDLE;
        else              w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) w_next = W_RESP;
                else if (aw_hs)    w_next = W_WAIT_W;
                else if (w_hs)     w_next = W_WAIT_AW;
            end
            W_WAIT_W:  if (w_hs)  w_next = W_RESP;
            W_WAIT_AW: if (aw_hs) w_next = W_RESP;
            W_RESP:    if (b_hs)  w_next = W_IDLE;
            default:   w_next = W_IDLE;
        endcase
    end

    always_comb begin
        S_AXI_AWREADY = ready_en && (w_state == W_IDLE || w_state == W_WAIT_AW);
        S_AXI_WREADY  = ready_en && (w_state == W_IDLE || w_state == W_WAIT_W);
        S_AXI_BVALID  = (w_state == W_RESP);
        S_AXI_BRESP   = RESP_OKAY;
    end

    // Commit happens when the second half arrives; the other half comes from the holding regs.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = aw_idx_q;
        wr_data = wdata_q;
        wr_strb = wstrb_q;
        case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    wr_en   = 1'b1;
                    wr_idx  = S_AXI_AWADDR[3:2];
                    wr_data = S_AXI_WDATA;
                    wr_strb = S_AXI_WSTRB;
                end
            end
            W_WAIT_W: begin
                if (w_hs) begin
                    wr_en   = 1'b1;
                    wr_data = S_AXI_WDATA;
                    wr_strb = S_AXI_WSTRB;
                end
            end
            W_WAIT_AW: begin
                if (aw_hs) begin
                    wr_en  = 1'b1;
                    wr_idx = S_AXI_AWADDR[3:2];
                end
            end
            default: wr_en = 1'b0;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (aw_hs) aw_idx_q <= S_AXI_AWADDR[3:2];
        if (w_hs) begin
            wdata_q <= S_AXI_WDATA;
            wstrb_q <= S_AXI_WSTRB;
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            start_o <= 1'b0;
        end else begin
            start_o <= wr_en && (wr_idx == REG0_IDX) && wr_strb[0] && wr_data[0];
            if (wr_en) regs[wr_idx] <= merge_bytes(regs[wr_idx], wr_data, wr_strb);
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) r_state <= R_IDLE;
        else              r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (r_hs)  r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        S_AXI_ARREADY = ready_en && (r_state == R_IDLE);
        S_AXI_RVALID  = (r_state == R_DATA);
        S_AXI_RRESP   = RESP_OKAY;
    end

    // Sampled before any same-edge register write lands, so reads see the old value.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET)  S_AXI_RDATA <= '0;
        else if (ar_hs)    S_AXI_RDATA <= regs[S_AXI_ARADDR[3:2]];
    end

    assign reg0_o = regs[REG0_IDX];
    assign reg1_o = regs[REG1_IDX];
    assign reg2_o = regs[REG2_IDX];
    assign reg3_o = regs[REG3_IDX];

endmodule

// File: tb/tb_accel_ip_axil_regs.sv
// Self-checking bench for accel_ip_axil_regs: vector table plus read-data scoreboard and corner sequences.
module tb_accel_ip_axil_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [31:0] reg0, reg1, reg2, reg3;
    logic        start;

    always #5 clk = ~clk;

    accel_ip_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .reg0_o(reg0), .reg1_o(reg1), .reg2_o(reg2), .reg3_o(reg3), .start_o(start)
    );

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] rd_exp;
    } vec_t;

    vec_t        vecs [8];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [4];
    logic [31:0] exp_q [$];
    logic [31:0] mon_exp;
    int          start_cnt = 0;
    int          start_exp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] reg_out(input int idx);
        case (idx)
            0:       return reg0;
            1:       return reg1;
            2:       return reg2;
            default: return reg3;
        endcase
    endfunction

    // Read-data scoreboard and write-response / start-pulse monitors.
    always @(negedge clk) begin
        if (start) start_cnt++;
        if (rvalid && rready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got 0x%08h, expected no read response", rdata);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("rdata", rdata, mon_exp);
                chk("rresp", {30'd0, rresp}, 32'd0);
            end
        end
        if (bvalid && bready) chk("bresp", {30'd0, bresp}, 32'd0);
    end

    // Called at posedge+1; returns at posedge+1 after the B handshake.
    task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int bhold);
        int   cyc;
        logic awd, wd, ahs, whs, bhs, st_exp;
        int   idx;
        idx = int'(addr[3:2]);
        bready = 1'b0;
        cyc = 0; awd = 1'b0; wd = 1'b0;
        while (!(awd && wd) && cyc < 50) begin
            if (!awd && cyc >= aw_dly) begin awvalid = 1'b1; awaddr = addr; end
            if (!wd && cyc >= w_dly) begin wvalid = 1'b1; wdata = data; wstrb = strb; end
            @(negedge clk);
            ahs = awvalid && awready;
            whs = wvalid && wready;
            if (!awd && whs && cyc < aw_dly) chk("reg_hold_before_aw", reg_out(idx), model[idx]);
            @(posedge clk); #1;
            if (ahs) begin awd = 1'b1; awvalid = 1'b0; end
            if (whs) begin wd = 1'b1; wvalid = 1'b0; end
            cyc++;
        end
        if (!(awd && wd)) begin
            chk("aw_w_timeout", {30'd0, awd, wd}, 32'd3);
            awvalid = 1'b0; wvalid = 1'b0;
            return;
        end
        for (int n = 0; n < 4; n++) if (strb[n]) model[idx][8*n +: 8] = data[8*n +: 8];
        st_exp = (idx == 0) && strb[0] && data[0];
        if (st_exp) start_exp_cnt++;
        @(negedge clk);
        chk("bvalid_latency", {31'd0, bvalid}, 32'd1);
        chk("start_pulse", {31'd0, start}, {31'd0, st_exp});
        chk("reg_after_write", reg_out(idx), model[idx]);
        @(posedge clk); #1;
        for (int i = 0; i < bhold; i++) begin
            @(negedge clk);
            chk("bvalid_stall", {31'd0, bvalid}, 32'd1);
            chk("bresp_stall", {30'd0, bresp}, 32'd0);
            chk("awready_stall", {31'd0, awready}, 32'd0);
            chk("wready_stall", {31'd0, wready}, 32'd0);
            @(posedge clk); #1;
        end
        bready = 1'b1;
        cyc = 0; bhs = 1'b0;
        while (!bhs && cyc < 50) begin
            @(negedge clk);
            bhs = bvalid && bready;
            @(posedge clk); #1;
            cyc++;
        end
        if (!bhs) chk("b_timeout", 32'd0, 32'd1);
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] addr, input logic [31:0] exp, input int rhold);
        int   cyc;
        logic hs;
        rready = 1'b0;
        araddr = addr;
        arvalid = 1'b1;
        exp_q.push_back(exp);
        cyc = 0; hs = 1'b0;
        while (!hs && cyc < 50) begin
            @(negedge clk);
            hs = arready;
            @(posedge clk); #1;
            cyc++;
        end
        arvalid = 1'b0;
        if (!hs) begin
            chk("ar_timeout", 32'd0, 32'd1);
            void'(exp_q.pop_back());
            return;
        end
        @(negedge clk);
        chk("rvalid_latency", {31'd0, rvalid}, 32'd1);
        @(posedge clk); #1;
        for (int i = 0; i < rhold; i++) begin
            @(negedge clk);
            chk("rvalid_stall", {31'd0, rvalid}, 32'd1);
            chk("rdata_stall", rdata, exp);
            chk("arready_stall", {31'd0, arready}, 32'd0);
            @(posedge clk); #1;
        end
        rready = 1'b1;
        cyc = 0; hs = 1'b0;
        while (!hs && cyc < 50) begin
            @(negedge clk);
            hs = rvalid && rready;
            @(posedge clk); #1;
            cyc++;
        end
        if (!hs) chk("r_timeout", 32'd0, 32'd1);
        rready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_awready"}, {31'd0, awready}, 32'd0);
        chk({tag, "_wready"},  {31'd0, wready},  32'd0);
        chk({tag, "_arready"}, {31'd0, arready}, 32'd0);
        chk({tag, "_bvalid"},  {31'd0, bvalid},  32'd0);
        chk({tag, "_rvalid"},  {31'd0, rvalid},  32'd0);
        chk({tag, "_start"},   {31'd0, start},   32'd0);
        chk({tag, "_rdata"},   rdata, 32'd0);
        chk({tag, "_regs"},    reg0 | reg1 | reg2 | reg3, 32'd0);
    endtask

    task automatic release_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_before_edge", {29'd0, awready, wready, arready}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ready_after_edge", {29'd0, awready, wready, arready}, 32'd7);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = '0;

        vecs[0] = '{4'h0, 32'h0000_0001, 4'hF, 32'h0000_0001};
        vecs[1] = '{4'h4, 32'h0000_0002, 4'hF, 32'h0000_0002};
        vecs[2] = '{4'h8, 32'h0000_0003, 4'hF, 32'h0000_0003};
        vecs[3] = '{4'hC, 32'h0000_0004, 4'hF, 32'h0000_0004};
        vecs[4] = '{4'hF, 32'hA5A5_A5A5, 4'hF, 32'hA5A5_A5A5};
        vecs[5] = '{4'h0, 32'h0000_0002, 4'hF, 32'h0000_0002};
        vecs[6] = '{4'h1, 32'hFFFF_FF01, 4'hE, 32'hFFFF_FF02};
        vecs[7] = '{4'h2, 32'h0000_0001, 4'h1, 32'hFFFF_FF01};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        release_reset();

        for (int i = 0; i < 8; i++) begin
            do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, 0);
            chk($sformatf("vec%0d_reg", i), reg_out(int'(vecs[i].addr[3:2])), vecs[i].rd_exp);
            do_read(vecs[i].addr, vecs[i].rd_exp, 0);
            if (i == 3) chk("start_count_first4", start_cnt, 1);
        end

        // W leads AW by three cycles.
        do_write(4'h8, 32'hDEAD_BEEF, 4'hF, 3, 0, 0);
        chk("w_first_reg2", reg2, 32'hDEAD_BEEF);
        do_read(4'h8, 32'hDEAD_BEEF, 0);

        // AW leads W.
        do_write(4'h4, 32'hFFFF_FFFF, 4'hF, 0, 2, 0);
        do_write(4'h4, 32'h1234_5678, 4'h5, 0, 0, 0);
        chk("strobe_reg1", reg1, 32'hFF34_FF78);
        do_read(4'h4, 32'hFF34_FF78, 0);

        // Response back-pressure.
        do_write(4'hC, 32'hCAFE_F00D, 4'hF, 0, 0, 5);
        do_read(4'hC, 32'hCAFE_F00D, 5);

        // Read and write to the same register accepted on the same edge.
        fork
            do_write(4'hC, 32'h0BAD_F00D, 4'hF, 0, 0, 0);
            do_read(4'hC, 32'hCAFE_F00D, 0);
        join
        do_read(4'hC, 32'h0BAD_F00D, 0);

        // Reset between the address and data halves of a write.
        awaddr = 4'h8; awvalid = 1'b1;
        @(negedge clk);
        chk("half_aw_ready", {31'd0, awready}, 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        @(negedge clk);
        chk("half_wait_w", {30'd0, awready, wready}, 32'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        for (int i = 0; i < 4; i++) model[i] = '0;
        release_reset();
        @(negedge clk);
        chk("post_reset_bvalid", {31'd0, bvalid}, 32'd0);
        chk("post_reset_regs", reg0 | reg1 | reg2 | reg3, 32'd0);
        @(posedge clk); #1;
        do_read(4'h8, 32'd0, 0);

        chk("start_count_total", start_cnt, start_exp_cnt);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
